// File: rtl/ysyx_24110006_idu_stage_pkg.sv
// Shared decode constants for the IDU stage: opcodes, format indices,
// buffer-occupancy states and the opcode-to-format classifier.
package ysyx_24110006_idu_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_MRET = 32'h3020_0073;

  localparam int FMT_I = 0;
  localparam int FMT_J = 1;
  localparam int FMT_U = 2;
  localparam int FMT_S = 3;
  localparam int FMT_B = 4;
  localparam int FMT_R = 5;
  localparam int FMT_W = 6;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } beat_t;

  // mret shares OP_SYSTEM with the I-format CSR ops but has no format class.
  function automatic logic [FMT_W-1:0] decode_fmt(input logic [31:0] inst);
    logic [FMT_W-1:0] f;
    f = '0;
    case (inst[6:0])
      OP_IMM, OP_JALR, OP_LOAD: f[FMT_I] = 1'b1;
      OP_SYSTEM:                f[FMT_I] = (inst != INST_MRET);
      OP_LUI, OP_AUIPC:         f[FMT_U] = 1'b1;
      OP_JAL:                   f[FMT_J] = 1'b1;
      OP_STORE:                 f[FMT_S] = 1'b1;
      OP_BRANCH:                f[FMT_B] = 1'b1;
      OP_REG:                   f[FMT_R] = 1'b1;
      default:                  f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ysyx_24110006_idu_stage_imm.sv
// Immediate generator: sign-extended RISC-V immediate for the given instruction,
// zero for mret and unsupported opcodes.
module ysyx_24110006_IMM
  import ysyx_24110006_idu_stage_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  logic [FMT_W-1:0] fmt;

  always_comb begin
    fmt = decode_fmt(inst);
    imm = '0;
    if (fmt[FMT_I])
      imm = {{20{inst[31]}}, inst[31:20]};
    else if (fmt[FMT_U])
      imm = {inst[31:12], 12'b0};
    else if (fmt[FMT_J])
      imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    else if (fmt[FMT_B])
      imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (fmt[FMT_S])
      imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
    else if (fmt[FMT_R])
      imm = {25'b0, inst[31:25]};
  end

endmodule

// File: rtl/ysyx_24110006_idu_stage.sv
// Decode stage: 2-entry skid buffer between IFU and EXU, head-beat decode,
// flush and saturating back-pressure counter.
module ysyx_24110006_idu_stage
  import ysyx_24110006_idu_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic [5:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0] state;
  beat_t      head;
  beat_t      skid;
  beat_t      in_beat;
  logic       acc;
  logic       pop;

  assign in_beat   = '{inst: in_inst, pc: in_pc};
  assign in_ready  = (state != S_TWO) && !flush;
  assign out_valid = (state != S_EMPTY);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flush wins over everything; a same-cycle pop is already consumed by EXU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (acc) begin
            head  <= in_beat;
            state <= S_ONE;
          end
        end
        S_ONE: begin
          if (acc && !pop) begin
            skid  <= in_beat;
            state <= S_TWO;
          end else if (!acc && pop) begin
            state <= S_EMPTY;
          end else if (acc && pop) begin
            head <= in_beat;
          end
        end
        S_TWO: begin
          if (pop) begin
            head  <= skid;
            state <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign out_inst    = head.inst;
  assign out_pc      = head.pc;
  assign out_fmt     = decode_fmt(head.inst);
  assign out_illegal = (out_fmt == '0) && (head.inst != INST_MRET);

  ysyx_24110006_IMM u_imm (
    .inst (head.inst),
    .imm  (out_imm)
  );

endmodule

// File: tb/tb_ysyx_24110006_idu_stage.sv
// Bench for the IDU stage: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_ysyx_24110006_idu_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [5:0]  out_fmt;
  logic        out_illegal;
  logic [31:0] stall_cnt;

  bit clk_run = 1'b1;
  bit chk_en  = 1'b0;
  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } mbeat_t;

  mbeat_t      mq[$];
  logic [31:0] m_stall = '0;

  ysyx_24110006_idu_stage #(.CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal),
    .stall_cnt   (stall_cnt)
  );

  always #5 if (clk_run) clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference decode written from the ISA field layout with integer arithmetic.
  function automatic void model_decode(input logic [31:0] inst, output logic [31:0] imm,
                                       output logic [5:0] fmt, output logic ill);
    int v;
    imm = 0;
    fmt = 0;
    ill = 0;
    case (inst[6:0])
      7'h13, 7'h67, 7'h03, 7'h73: begin
        if (inst != 32'h3020_0073) begin
          fmt = 6'b000001;
          v = int'(inst[31:20]);
          if (v >= 2048) v -= 4096;
          imm = 32'(v);
        end
      end
      7'h37, 7'h17: begin
        fmt = 6'b000100;
        imm = inst & 32'hFFFF_F000;
      end
      7'h6F: begin
        fmt = 6'b000010;
        v = int'(inst[31]) * (1 << 20) + int'(inst[19:12]) * 4096
            + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
        imm = 32'(v);
      end
      7'h23: begin
        fmt = 6'b001000;
        v = int'(inst[31:25]) * 32 + int'(inst[11:7]);
        if (v >= 2048) v -= 4096;
        imm = 32'(v);
      end
      7'h63: begin
        fmt = 6'b010000;
        v = int'(inst[31]) * 4096 + int'(inst[7]) * 2048
            + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
        if (v >= 4096) v -= 8192;
        imm = 32'(v);
      end
      7'h33: begin
        fmt = 6'b100000;
        imm = inst >> 25;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Occupancy model: a FIFO of at most two beats.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_stall = '0;
    end else begin
      bit m_rdy;
      bit m_vld;
      m_rdy = (mq.size() < 2) && !flush;
      m_vld = (mq.size() > 0);
      if (m_vld && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush) mq.delete();
      else begin
        if (m_vld && out_ready) void'(mq.pop_front());
        if (in_valid && m_rdy) mq.push_back('{inst: in_inst, pc: in_pc});
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && chk_en) begin
      logic [31:0] e_imm;
      logic [5:0]  e_fmt;
      logic        e_ill;
      check_output("model_in_ready", 32'(in_ready), 32'((mq.size() < 2) && !flush));
      check_output("model_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check_output("model_stall_cnt", stall_cnt, m_stall);
      if (mq.size() > 0) begin
        model_decode(mq[0].inst, e_imm, e_fmt, e_ill);
        check_output("model_out_inst", out_inst, mq[0].inst);
        check_output("model_out_pc", out_pc, mq[0].pc);
        check_output("model_out_imm", out_imm, e_imm);
        check_output("model_out_fmt", 32'(out_fmt), 32'(e_fmt));
        check_output("model_out_illegal", 32'(out_illegal), 32'(e_ill));
      end
    end
  end

  task automatic set_inputs(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                            input logic ordy, input logic fl);
    in_valid  = iv;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic apply_stimulus(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                                input logic ordy, input logic fl);
    set_inputs(iv, inst, pc, ordy, fl);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_inputs(1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  logic [31:0] vec_inst [7] = '{32'h3020_0073, 32'h0000_000B, 32'hFE11_2E23, 32'hFE00_0CE3,
                                32'h4031_00B3, 32'h1234_5037, 32'h0080_006F};
  logic [31:0] vec_imm  [7] = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8,
                                32'h20, 32'h1234_5000, 32'h8};
  logic [5:0]  vec_fmt  [7] = '{6'b000000, 6'b000000, 6'b001000, 6'b010000,
                                6'b100000, 6'b000100, 6'b000010};
  logic        vec_ill  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #1;
    check_output("rst_out_valid", 32'(out_valid), 32'h0);
    check_output("rst_in_ready", 32'(in_ready), 32'h1);
    check_output("rst_stall_cnt", stall_cnt, 32'h0);
    check_output("rst_out_inst", out_inst, 32'h0);
    check_output("rst_out_fmt", 32'(out_fmt), 32'h0);
    do_reset();
    chk_en = 1'b1;

    // Single addi beat.
    apply_stimulus(1'b1, 32'h0050_0093, 32'h8000_0000, 1'b1, 1'b0);
    check_output("t1_out_valid", 32'(out_valid), 32'h1);
    check_output("t1_out_pc", out_pc, 32'h8000_0000);
    check_output("t1_imm", out_imm, 32'h5);
    check_output("t1_fmt", 32'(out_fmt), 32'h01);
    check_output("t1_illegal", 32'(out_illegal), 32'h0);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    check_output("t1_empty", 32'(out_valid), 32'h0);

    // Fill both entries under back-pressure, then drain in order.
    do_reset();
    apply_stimulus(1'b1, 32'hFFF0_0093, 32'h10, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h0000_006F, 32'h14, 1'b0, 1'b0);
    check_output("t2_in_ready_full", 32'(in_ready), 32'h0);
    check_output("t2_head_imm", out_imm, 32'hFFFF_FFFF);
    check_output("t2_head_pc", out_pc, 32'h10);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    check_output("t2_second_inst", out_inst, 32'h0000_006F);
    check_output("t2_second_imm", out_imm, 32'h0);
    check_output("t2_second_fmt", 32'(out_fmt), 32'h02);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    check_output("t2_drained", 32'(out_valid), 32'h0);

    // Streaming at full throughput.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b1, {i[11:0], 20'h00093}, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      check_output("t3_stream_pc", out_pc, 32'h100 + 32'(4 * i));
      check_output("t3_stream_valid", 32'(out_valid), 32'h1);
    end
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    check_output("t3_done_valid", 32'(out_valid), 32'h0);
    check_output("t3_stall_cnt", stall_cnt, 32'h0);

    // Flush while full with a competing in_valid.
    do_reset();
    apply_stimulus(1'b1, 32'h0010_0093, 32'h200, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h0020_0093, 32'h204, 1'b0, 1'b0);
    set_inputs(1'b1, 32'h0030_0093, 32'h208, 1'b0, 1'b1);
    #1 check_output("t4_in_ready_flush", 32'(in_ready), 32'h0);
    @(posedge clock);
    #1 set_inputs(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check_output("t4_out_valid", 32'(out_valid), 32'h0);
    check_output("t4_in_ready", 32'(in_ready), 32'h1);
    apply_stimulus(1'b1, 32'h0040_0093, 32'h20C, 1'b1, 1'b0);
    check_output("t4_next_pc", out_pc, 32'h20C);
    apply_stimulus(1'b1, 32'h0050_0093, 32'h210, 1'b1, 1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    check_output("t4_flush_pop_valid", 32'(out_valid), 32'h0);

    // Format/immediate table including mret and an illegal opcode.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, vec_inst[i], 32'h300 + 32'(4 * i), 1'b1, 1'b0);
      check_output("t5_imm", out_imm, vec_imm[i]);
      check_output("t5_fmt", 32'(out_fmt), 32'(vec_fmt[i]));
      check_output("t5_illegal", 32'(out_illegal), 32'(vec_ill[i]));
    end
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall counting, then asynchronous reset with the clock stopped.
    do_reset();
    apply_stimulus(1'b1, 32'h0070_0093, 32'h400, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
    check_output("t6_stall_cnt", stall_cnt, 32'h7);
    check_output("t6_held_valid", 32'(out_valid), 32'h1);
    @(negedge clock);
    clk_run = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_output("t6_async_valid", 32'(out_valid), 32'h0);
    check_output("t6_async_in_ready", 32'(in_ready), 32'h1);
    check_output("t6_async_stall", stall_cnt, 32'h0);
    check_output("t6_async_inst", out_inst, 32'h0);
    check_output("t6_async_pc", out_pc, 32'h0);
    check_output("t6_async_imm", out_imm, 32'h0);
    check_output("t6_async_fmt", 32'(out_fmt), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
